// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between the IF (read-only) and MEM (read/write) requesters.
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention; default is fixed MEM-over-IF.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cnt;
  logic              r_gnt_if;
  logic              r_gnt_mem;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;

  logic w_mem_want;
  logic w_any;
  logic w_pick_mem;
  logic w_start;
  logic w_last_cyc;

  assign w_mem_want = mem_rd_req | mem_wr_req;
  assign w_any      = if_req | w_mem_want;
  assign w_start    = (r_state == ST_IDLE) & w_any;
  assign w_last_cyc = (r_state == ST_ACCESS) & (r_cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = MEM held the previous grant; under contention the other side wins.
  logic r_last_mem;

  assign w_pick_mem = w_mem_want & (~if_req | ~r_last_mem);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_mem <= 1'b0;
    end else if (w_start) begin
      r_last_mem <= w_pick_mem;
    end
  end
`else
  assign w_pick_mem = w_mem_want;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next_state = ST_ACCESS;
      ST_ACCESS: if (r_cnt == 4'd0) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Grant and access parameters are frozen at the start of each access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 4'd0;
      r_gnt_if  <= 1'b0;
      r_gnt_mem <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_start) begin
      r_cnt     <= 4'(WAIT_CYCLES - 1);
      r_gnt_if  <= ~w_pick_mem;
      r_gnt_mem <= w_pick_mem;
      r_we      <= w_pick_mem & mem_wr_req;
      r_addr    <= w_pick_mem ? mem_addr : if_addr;
      r_wdata   <= mem_wdata;
    end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
      r_cnt     <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else if (w_last_cyc && !r_we) begin
      if (r_gnt_if)  r_if_rdata  <= sram_rdata;
      if (r_gnt_mem) r_mem_rdata <= sram_rdata;
    end
  end

  // Ready is suppressed when the granted side has already dropped its request.
  assign sram_en    = (r_state == ST_ACCESS);
  assign sram_we    = sram_en & r_we;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign if_ready   = (r_state == ST_DONE) & r_gnt_if & if_req;
  assign mem_ready  = (r_state == ST_DONE) & r_gnt_mem & w_mem_want;
  assign if_stall   = if_req & ~if_ready;
  assign mem_stall  = w_mem_want & ~mem_ready;
  assign if_rdata   = r_if_rdata;
  assign mem_rdata  = r_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;
  localparam int W = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_rd_req, mem_wr_req;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        if_ready, if_stall, mem_ready, mem_stall, sram_en, sram_we;
  logic [31:0] d1_if_rdata, d1_mem_rdata, d1_sram_addr, d1_sram_wdata;
  logic        d1_if_ready, d1_if_stall, d1_mem_ready, d1_mem_stall, d1_sram_en, d1_sram_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(d1_if_rdata), .if_ready(d1_if_ready),
    .if_stall(d1_if_stall),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(d1_mem_rdata), .mem_ready(d1_mem_ready), .mem_stall(d1_mem_stall),
    .sram_en(d1_sram_en), .sram_we(d1_sram_we), .sram_addr(d1_sram_addr), .sram_wdata(d1_sram_wdata),
    .sram_rdata(32'h5A5A_0001)
  );

  // 8-word SRAM behind the main DUT, reloaded with a known pattern while reset is held.
  logic [31:0] sram_mem [8];

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hE3A0_1005 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  assign sram_rdata = sram_mem[sram_addr[4:2]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) sram_mem[i] <= init_val(i);
    end else if (sram_en && sram_we) begin
      sram_mem[sram_addr[4:2]] <= sram_wdata;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: an access occupies phases 1..W (SRAM enabled) and phase W+1 (completion); 0 means free.
  int          m_phase;
  bit          m_mem, m_we, m_last_mem;
  logic [31:0] m_addr, m_wdata, e_if_rd, e_mem_rd;
  logic [31:0] ref_mem [8];

  task automatic model_reset();
    m_phase = 0; m_mem = 0; m_we = 0; m_last_mem = 0;
    m_addr = 0; m_wdata = 0; e_if_rd = 0; e_mem_rd = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic model_step();
    bit want_if, want_mem, pick_mem;
    want_if  = if_req;
    want_mem = mem_rd_req | mem_wr_req;
    if (!rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (want_if || want_mem) begin
        pick_mem   = RR ? (want_mem && (!want_if || !m_last_mem)) : want_mem;
        m_mem      = pick_mem;
        m_last_mem = pick_mem;
        m_addr     = pick_mem ? mem_addr : if_addr;
        m_wdata    = mem_wdata;
        m_we       = pick_mem && mem_wr_req;
        m_phase    = 1;
      end
    end else begin
      if (m_phase <= W && m_we) ref_mem[m_addr[4:2]] = m_wdata;
      if (m_phase == W && !m_we) begin
        if (m_mem) e_mem_rd = ref_mem[m_addr[4:2]];
        else       e_if_rd  = ref_mem[m_addr[4:2]];
      end
      m_phase = (m_phase == W + 1) ? 0 : m_phase + 1;
    end
  endtask

  task automatic check_all();
    bit en, done, ifr, memr;
    en   = (m_phase >= 1) && (m_phase <= W);
    done = (m_phase == W + 1);
    ifr  = done && !m_mem && if_req;
    memr = done && m_mem && (mem_rd_req || mem_wr_req);
    chk("sram_en", 32'(sram_en), 32'(en));
    chk("sram_we", 32'(sram_we), 32'(en && m_we));
    chk("sram_addr", sram_addr, m_addr);
    chk("sram_wdata", sram_wdata, m_wdata);
    chk("if_ready", 32'(if_ready), 32'(ifr));
    chk("mem_ready", 32'(mem_ready), 32'(memr));
    chk("if_stall", 32'(if_stall), 32'(if_req && !ifr));
    chk("mem_stall", 32'(mem_stall), 32'((mem_rd_req || mem_wr_req) && !memr));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("mem_rdata", mem_rdata, e_mem_rd);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  logic [31:0] keep;
  int          op;

  initial begin
    rst = 1'b0; if_req = 0; mem_rd_req = 0; mem_wr_req = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;

    // IF read of 0x10
    if_req = 1; if_addr = 32'h10;
    tick(); chk("t1_en1", 32'(sram_en), 1); chk("t1_addr", sram_addr, 32'h10); chk("t1_we", 32'(sram_we), 0);
    tick(); chk("t1_en2", 32'(sram_en), 1);
    tick(); chk("t1_rdy", 32'(if_ready), 1); chk("t1_rdata", if_rdata, 32'hE3A0_1005);
    chk("t1_stall", 32'(if_stall), 0);
    if_req = 0;
    tick();

    // MEM write of 0xDEADBEEF to 0x200
    mem_wr_req = 1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
    tick(); chk("t2_en", 32'(sram_en), 1); chk("t2_we", 32'(sram_we), 1); chk("t2_wd", sram_wdata, 32'hDEAD_BEEF);
    tick(); chk("t2_we2", 32'(sram_we), 1);
    tick(); chk("t2_rdy", 32'(mem_ready), 1); chk("t2_ifrdy", 32'(if_ready), 0);
    mem_wr_req = 0;
    tick();

    // Simultaneous IF and MEM reads
    if_req = 1; if_addr = 32'h40; mem_rd_req = 1; mem_addr = 32'h300;
    repeat (3) tick();
    chk("t3_first", {30'd0, mem_ready, if_ready}, RR ? 32'd1 : 32'd2);
    if (RR) if_req = 0; else mem_rd_req = 0;
    repeat (4) tick();
    chk("t3_second", {30'd0, mem_ready, if_ready}, RR ? 32'd2 : 32'd1);
    if_req = 0; mem_rd_req = 0;
    tick();

    // Read and write together behave as a write
    keep = e_mem_rd;
    mem_rd_req = 1; mem_wr_req = 1; mem_addr = 32'h8; mem_wdata = 32'h1234_5678;
    tick(); chk("t4_we", 32'(sram_we), 1);
    tick();
    tick(); chk("t4_rdy", 32'(mem_ready), 1); chk("t4_rdata", mem_rdata, keep);
    mem_rd_req = 0; mem_wr_req = 0;
    tick();

    // IF drops its request mid-access
    if_req = 1; if_addr = 32'h14;
    tick();
    if_req = 0;
    tick(); chk("t5_en2", 32'(sram_en), 1);
    tick(); chk("t5_nordy", 32'(if_ready), 0);
    tick(); chk("t5_idle", 32'(sram_en), 0);

    // Reset during the first cycle of a write
    mem_wr_req = 1; mem_addr = 32'h1C; mem_wdata = 32'hCAFE_F00D;
    tick(); chk("t6_en", 32'(sram_en), 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_en", 32'(sram_en), 0); chk("t6_rst_we", 32'(sram_we), 0);
    mem_wr_req = 0;
    model_reset();
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // WAIT_CYCLES=1 instance: ready one cycle earlier
    if_req = 1; if_addr = 32'h10;
    tick(); chk("w1_rdy_c1", 32'(d1_if_ready), 0);
    tick(); chk("w1_rdy_c2", 32'(d1_if_ready), 1);
    tick(); chk("w1_main_c3", 32'(if_ready), 1);
    if_req = 0;
    tick();

    // Random traffic with occasional aborts and resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #1;
        chk("rnd_rst_en", 32'(sram_en), 0);
        model_reset();
        tick();
        rst = 1'b1;
      end
      if (if_req) begin
        if (if_ready || $urandom_range(0, 29) == 0) if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (mem_rd_req || mem_wr_req) begin
        if (mem_ready || $urandom_range(0, 29) == 0) begin
          mem_rd_req = 0; mem_wr_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        op = int'($urandom_range(0, 2));
        mem_rd_req = (op != 1); mem_wr_req = (op != 0);
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
